// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared encodings, state enum and per-state control table for the multi-cycle core
package core_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_BEQ  = 4'b1001;
  localparam logic [3:0] ALU_BNE  = 4'b1100;
  localparam logic [3:0] ALU_BLT  = 4'b1101;
  localparam logic [3:0] ALU_BGE  = 4'b1110;
  localparam logic [3:0] ALU_JALR = 4'b1111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] BSEL_RS2  = 2'd0;
  localparam logic [1:0] BSEL_IMM  = 2'd1;
  localparam logic [1:0] BSEL_FOUR = 2'd2;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R      = 3'd0,
    C_I      = 3'd1,
    C_LOAD   = 3'd2,
    C_STORE  = 3'd3,
    C_BRANCH = 3'd4,
    C_JAL    = 3'd5,
    C_JALR   = 3'd6,
    C_ILL    = 3'd7
  } iclass_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic [3:0] aluctl;
    logic       alu_a_sel;
    logic [1:0] alu_b_sel;
    logic       pc_we;
    logic       rf_we;
    logic [1:0] wb_sel;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{
    mem_req:      1'b0,
    mem_we:       1'b0,
    mem_addr_sel: 1'b0,
    aluctl:       ALU_ADD,
    alu_a_sel:    1'b0,
    alu_b_sel:    BSEL_RS2,
    pc_we:        1'b0,
    rf_we:        1'b0,
    wb_sel:       WB_ALU
  };

  // Control word that is valid while the FSM sits in state s with instruction class c.
  function automatic ctl_t ctl_for(input state_t s, input iclass_t c,
                                   input logic [3:0] op_alu, input logic rd_nz);
    ctl_t k;
    k = CTL_IDLE;
    case (s)
      S_IF: k.mem_req = 1'b1;
      S_EX: begin
        case (c)
          C_R: k.aluctl = op_alu;
          C_I: begin
            k.aluctl    = op_alu;
            k.alu_b_sel = BSEL_IMM;
          end
          C_LOAD, C_STORE: k.alu_b_sel = BSEL_IMM;
          C_BRANCH: begin
            k.aluctl    = op_alu;
            k.alu_a_sel = 1'b1;
            k.alu_b_sel = BSEL_IMM;
            k.pc_we     = 1'b1;
          end
          C_JAL, C_JALR: begin
            k.aluctl    = op_alu;
            k.alu_a_sel = (c == C_JAL);
            k.alu_b_sel = BSEL_IMM;
            k.pc_we     = 1'b1;
            k.rf_we     = rd_nz;
            k.wb_sel    = WB_PC4;
          end
          default: k = CTL_IDLE;
        endcase
      end
      S_MEM: begin
        k.mem_req      = 1'b1;
        k.mem_addr_sel = 1'b1;
        k.mem_we       = (c == C_STORE);
      end
      S_WB: begin
        k.rf_we  = rd_nz;
        k.wb_sel = (c == C_LOAD) ? WB_MEM : WB_ALU;
      end
      default: k = CTL_IDLE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ctl_decode.sv
// rtl/ctl_decode.sv - combinational instruction classifier and ALU operation decoder
module ctl_decode
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] cls,
  output logic [3:0] aluctl,
  output logic       illegal
);

  iclass_t c;

  always_comb begin
    c      = C_ILL;
    aluctl = ALU_ADD;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD: begin c = C_R; aluctl = ALU_ADD; end
            F3_SLT: begin c = C_R; aluctl = ALU_SLT; end
            F3_OR:  begin c = C_R; aluctl = ALU_OR;  end
            F3_AND: begin c = C_R; aluctl = ALU_AND; end
            default: c = C_ILL;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          c      = C_R;
          aluctl = ALU_SUB;
        end
      end
      OP_I: begin
        case (funct3)
          F3_ADD: begin c = C_I; aluctl = ALU_ADD; end
          F3_SLT: begin c = C_I; aluctl = ALU_SLT; end
          F3_OR:  begin c = C_I; aluctl = ALU_OR;  end
          F3_AND: begin c = C_I; aluctl = ALU_AND; end
          default: c = C_ILL;
        endcase
      end
      OP_LOAD:  if (funct3 == F3_LW) c = C_LOAD;
      OP_STORE: if (funct3 == F3_SW) c = C_STORE;
      OP_BRANCH: begin
        case (funct3)
          F3_BEQ: begin c = C_BRANCH; aluctl = ALU_BEQ; end
          F3_BNE: begin c = C_BRANCH; aluctl = ALU_BNE; end
          F3_BLT: begin c = C_BRANCH; aluctl = ALU_BLT; end
          F3_BGE: begin c = C_BRANCH; aluctl = ALU_BGE; end
          default: c = C_ILL;
        endcase
      end
      OP_JAL: c = C_JAL;
      OP_JALR: begin
        if (funct3 == F3_JALR) begin
          c      = C_JALR;
          aluctl = ALU_JALR;
        end
      end
      default: c = C_ILL;
    endcase
  end

  assign cls     = c;
  assign illegal = (c == C_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - IF/ID/EX/MEM/WB control sequencer driving the ALU and datapath selects
module multicycle_ctrl
  import core_pkg::*;
#(
  parameter bit RESET_STATE_TRAP = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [31:0] ir,
  output logic [3:0]  ALUctl,
  output logic        alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic        pc_inc,
  output logic        pc_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal
);

  state_t     state;
  ctl_t       ctl;
  logic [2:0] dec_cls_raw;
  iclass_t    dec_cls;
  logic [3:0] dec_alu;
  logic       dec_illegal;
  logic [6:0] dec_op;
  logic [2:0] dec_f3;
  logic [6:0] dec_f7;
  logic       rd_nz;
  logic       fetch_done;

  // While fetching, decode the incoming word so the ID-cycle illegal flag can be registered.
  assign dec_op = (state == S_IF) ? mem_rdata[6:0]   : ir[6:0];
  assign dec_f3 = (state == S_IF) ? mem_rdata[14:12] : ir[14:12];
  assign dec_f7 = (state == S_IF) ? mem_rdata[31:25] : ir[31:25];

  ctl_decode u_decode (
    .opcode  (dec_op),
    .funct3  (dec_f3),
    .funct7  (dec_f7),
    .cls     (dec_cls_raw),
    .aluctl  (dec_alu),
    .illegal (dec_illegal)
  );

  assign dec_cls    = iclass_t'(dec_cls_raw);
  assign rd_nz      = (ir[11:7] != 5'd0);
  assign fetch_done = (state == S_IF) && ctl.mem_req && mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IF;
      ir      <= '0;
      illegal <= 1'b0;
      ctl     <= CTL_IDLE;
    end else begin
      case (state)
        S_IF: begin
          if (fetch_done) begin
            ir      <= mem_rdata;
            illegal <= dec_illegal;
            state   <= S_ID;
            ctl     <= CTL_IDLE;
          end else begin
            ctl <= ctl_for(S_IF, dec_cls, dec_alu, rd_nz);
          end
        end
        S_ID: begin
          if (illegal) begin
            if (RESET_STATE_TRAP) begin
              state <= S_TRAP;
              ctl   <= CTL_IDLE;
            end else begin
              illegal <= 1'b0;
              state   <= S_IF;
              ctl     <= ctl_for(S_IF, dec_cls, dec_alu, rd_nz);
            end
          end else begin
            state <= S_EX;
            ctl   <= ctl_for(S_EX, dec_cls, dec_alu, rd_nz);
          end
        end
        S_EX: begin
          case (dec_cls)
            C_R, C_I: begin
              state <= S_WB;
              ctl   <= ctl_for(S_WB, dec_cls, dec_alu, rd_nz);
            end
            C_LOAD, C_STORE: begin
              state <= S_MEM;
              ctl   <= ctl_for(S_MEM, dec_cls, dec_alu, rd_nz);
            end
            default: begin
              state <= S_IF;
              ctl   <= ctl_for(S_IF, dec_cls, dec_alu, rd_nz);
            end
          endcase
        end
        S_MEM: begin
          // Request/address/write-enable stay untouched until the memory accepts.
          if (mem_ready) begin
            if (dec_cls == C_LOAD) begin
              state <= S_WB;
              ctl   <= ctl_for(S_WB, dec_cls, dec_alu, rd_nz);
            end else begin
              state <= S_IF;
              ctl   <= ctl_for(S_IF, dec_cls, dec_alu, rd_nz);
            end
          end
        end
        S_WB: begin
          state <= S_IF;
          ctl   <= ctl_for(S_IF, dec_cls, dec_alu, rd_nz);
        end
        S_TRAP: begin
          state <= S_TRAP;
          ctl   <= CTL_IDLE;
        end
        default: begin
          state <= S_IF;
          ctl   <= CTL_IDLE;
        end
      endcase
    end
  end

  assign mem_req      = ctl.mem_req;
  assign mem_we       = ctl.mem_we;
  assign mem_addr_sel = ctl.mem_addr_sel;
  assign ALUctl       = ctl.aluctl;
  assign alu_a_sel    = ctl.alu_a_sel;
  assign alu_b_sel    = ctl.alu_b_sel;
  assign pc_we        = ctl.pc_we;
  assign rf_we        = ctl.rf_we;
  assign wb_sel       = ctl.wb_sel;
  assign pc_inc       = fetch_done;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the RV32I-subset core. It is the initiator side of the ALU interface: it fetches each instruction over a ready-handshake memory port, decodes it, and drives `ALUctl` and the datapath selects cycle by cycle through FETCH/DECODE/EXECUTE/MEM/WB. Branch resolution stays in the ALU, which consumes `BrEq`/`BrLT`; this block only issues the branch `ALUctl` code and loads `ALUOut` into the PC.

## Interface
Parameters:
- `RESET_STATE_TRAP`, default 0; when 1, an illegal opcode makes `S_TRAP` sticky until reset; when 0, the illegal instruction is skipped (PC already advanced) and fetch resumes.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mem_rdata`  in  32  instruction or load data
- `mem_ready`  in  1  memory completes the current request this cycle
- `mem_req`  out  1  memory request valid
- `mem_we`  out  1  store (1) / read (0)
- `mem_addr_sel`  out  1  0 = PC, 1 = ALUOut
- `ir`  out  32  latched instruction register
- `ALUctl`  out  4  ALU operation code
- `alu_a_sel`  out  1  0 = rs1, 1 = OldPC
- `alu_b_sel`  out  2  0 = rs2, 1 = immediate, 2 = constant 4
- `pc_inc`  out  1  PC <= PC+4 and OldPC <= PC in the datapath
- `pc_we`  out  1  PC <= ALUOut
- `rf_we`  out  1  register-file write
- `wb_sel`  out  2  0 = ALUOut, 1 = load data, 2 = OldPC+4
- `illegal`  out  1  undecodable instruction seen

## Operation
- ALUctl codes: add 0001, sub 0100, slt 0110, and 0111, or 1000, beq 1001, bne 1100, blt 1101, bge 1110, jalr 1111.
- Supported opcodes:
  - R 0110011: add, sub (funct7 0100000), slt, or, and.
  - I 0010011: addi, slti, ori, andi.
  - lw 0000011 (funct3 010).
  - sw 0100011 (funct3 010).
  - branch 1100011 (funct3 000/001/100/101).
  - jal 1101111.
  - jalr 1100111.
  - Every other opcode/funct combination is illegal.
- States: S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP. Transitions:
  - S_IF: `mem_req`=1, `mem_addr_sel`=0. On `mem_ready`: latch `ir`, pulse `pc_inc`, go to S_ID; otherwise stay in S_IF.
  - S_ID: decode `ir`. Illegal: pulse `illegal` (sticky if `RESET_STATE_TRAP`), then go to S_TRAP or S_IF. Legal: go to S_EX.
  - S_EX, R/I: ALU op on rs1 and rs2/imm, go to S_WB.
  - S_EX, lw/sw: add with B = imm, go to S_MEM.
  - S_EX, branch: `alu_a_sel`=1, `alu_b_sel`=1, branch code, `pc_we`=1, go to S_IF.
  - S_EX, jal: add with A = OldPC, B = imm, `pc_we`=1, `rf_we`=1, `wb_sel`=2, go to S_IF.
  - S_EX, jalr: code 1111 with A = rs1, B = imm, same PC/writeback as jal, go to S_IF.
  - S_MEM: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=(sw). On `mem_ready`: lw goes to S_WB, sw goes to S_IF. Otherwise hold.
  - S_WB: `rf_we`=1, `wb_sel`=0 for R/I, 1 for lw; go to S_IF.
- `rf_we` is suppressed when rd = x0.
- All controls are Moore outputs of state and `ir`, except the `pc_inc`/ir-latch strobe in S_IF, which is gated by `mem_ready`.

## Timing
- Reset (async assert, sync release):
  - state = S_IF, `ir` = 0, `illegal` = 0, `ALUctl` = 0001.
  - All strobes/selects 0. `mem_req` rises in the first cycle after release.
- Minimum latency with zero-wait memory: branch/jal/jalr 3 cycles, R/I 4, sw 4, lw 5. Each wait cycle on `mem_ready` adds one cycle.
- `mem_req`, `mem_we` and address select are held stable until `mem_ready`. They drop the cycle after completion.
- Reset asserted mid-request abandons the request immediately; `mem_req` goes to 0 asynchronously.
- `pc_we` and `pc_inc` are never asserted in the same cycle.

## Structure
- Package `core_pkg` holds:
  - ALUctl localparams.
  - Opcode/funct3/funct7 constants.
  - State enum.
  - `wb_sel`/`alu_b_sel` encodings.
- Sub-module `ctl_decode` (combinational): `ir` in; instruction class, ALUctl, illegal flag out. The FSM instantiates it once.

## Test plan
- `ir` 0x002081B3 (add x3,x1,x2), zero-wait -> IF,ID,EX,WB; `ALUctl`=0001 in EX; `rf_we`=1 with `wb_sel`=0 in cycle 4; next `mem_req` in cycle 5.
- 0x402081B3 (sub) with `mem_ready` low for 2 IF cycles -> `mem_req` held 3 cycles; `ALUctl`=0100; total 6 cycles.
- 0x00208463 (beq x1,x2,+8) -> EX shows `ALUctl`=1001, `alu_a_sel`=1, `alu_b_sel`=1, `pc_we`=1; `rf_we` never asserted; 3 cycles.
- 0x0000A283 (lw x5,0(x1)) with 1 MEM wait -> `mem_addr_sel`=1, `mem_we`=0 for 2 cycles, then `rf_we`=1 with `wb_sel`=1; 6 cycles.
- 0xFFFFFFFF with `RESET_STATE_TRAP`=1 -> `illegal`=1 in ID, FSM parks in S_TRAP with no further `mem_req`. Asserting `rst_n`=0 -> `illegal`=0 and FSM returns to S_IF.
- `rst_n` pulsed low during the S_MEM of an sw -> `mem_req`/`mem_we` fall immediately; fetch restarts after release.
